acionador_lampada: RTL and testbench
====================================

// Module: acionador_lampada
// PURPOSE
//   Lamp-side receiver for the 2-bit lamp command produced by the switch/sensor
//   arbitration logic. Filters command glitches, ramps brightness smoothly toward
//   the commanded level, and drives the lamp with a PWM signal. It also turns the
//   lamp off after a long absence of presence and reports its status.
// PARAMETERS
//   RAMP_DIV        4     clock cycles per 1-LSB brightness step (>=1)
//   STABLE_CYCLES   3     consecutive equal samples needed to accept a command (>=1)
//   TIMEOUT_CYCLES  1000  cycles with presenca=0 before forced off (>=1)
// PORTS
//   clock           in   1  single clock; every register updates on its rising edge
//   reset           in   1  synchronous, active-high
//   cmd             in   2  raw command: 00 off, 01 level 85, 10 level 170, 11 level 255
//   presenca        in   1  OR of room sensors; 1 = occupied
//   lampada         out  1  PWM drive to the lamp
//   brilho          out  8  current brightness, 0..255
//   estado          out  2  00 DESLIGADA, 01 SUBINDO, 10 ESTAVEL, 11 DESCENDO
//   cmd_aceito      out  2  filtered command currently in force
//   apagou_timeout  out  1  1 while lamp is forced off by timeout
// BEHAVIOUR
//   Reset: every output 0, estado=DESLIGADA, internal candidate/counters/PWM = 0.
//   Filter: candidate reg + counter. cmd!=cand -> cand<=cmd, cnt<=1. Else, if
//     cnt<STABLE_CYCLES, cnt++. cmd_aceito<=cand on the edge where cnt reaches
//     STABLE_CYCLES. The new value is visible after the STABLE_CYCLES-th consecutive
//     equal sample. Shorter pulses never reach cmd_aceito.
//   Target: alvo = apagou_timeout ? 0 : {0,85,170,255}[cmd_aceito].
//   Timeout: presenca=1 -> idle counter<=0, apagou_timeout<=0 on that same edge.
//     presenca=0 and alvo-from-cmd!=0 -> counter++. apagou_timeout<=1 on the edge
//     where the counter reaches TIMEOUT_CYCLES. The flag then holds until presenca=1.
//     The counter saturates and never wraps.
//   FSM (evaluated each edge with the current brilho and alvo):
//     brilho<alvo -> SUBINDO; brilho>alvo -> DESCENDO;
//     brilho==alvo -> DESLIGADA if alvo==0, else ESTAVEL.
//   Ramp: prescaler counts 0..RAMP_DIV-1 while in SUBINDO/DESCENDO and is held
//     at 0 in other states. On wrap, brilho moves +-1 toward alvo.
//     First step occurs RAMP_DIV cycles after entering a ramp.
//     A full 0->255 ramp takes 255*RAMP_DIV cycles.
//     An alvo change mid-ramp reverses or retargets immediately. brilho is never
//     reset, never overshoots alvo, and never wraps past 0 or 255.
//   PWM: 8-bit counter 0..254 (period 255), free-running from reset.
//     lampada = (pwm_cnt < brilho), registered: 1-cycle latency.
//     brilho=0 -> lampada always 0; brilho=255 -> lampada always 1.
//   Simultaneous events: a new accepted command and a timeout on the same edge
//     -> timeout wins (alvo=0). presenca=1 on that edge -> timeout not set.
//   reset asserted mid-ramp: next edge brilho=0, DESLIGADA, lampada=0,
//     with no ramp-down.
// TESTING
//   1 reset=1 two cycles, cmd=11 -> all outputs 0, estado=00; hold 10 cycles after
//     release with cmd=00 -> unchanged.
//   2 cmd=11 held, presenca=1, RAMP_DIV=4 -> cmd_aceito=11 after 3 samples, estado=01,
//     brilho=255 after 1020 more cycles, then estado=10 and lampada constantly 1.
//   3 From ESTAVEL at 255, 2-cycle glitch cmd=00 then back to 11 -> cmd_aceito stays
//     11 and brilho stays 255.
//   4 Ramp-up to 11 interrupted at brilho=100 by a stable cmd=01 -> estado=11,
//     brilho falls to 85, then estado=10. No value below 85 appears.
//   5 brilho=170, presenca=0 for TIMEOUT_CYCLES=1000 -> apagou_timeout=1, ramp down to
//     0 and estado=00. presenca=1 -> flag clears, ramp back up to 170.
//   6 brilho=85 steady -> lampada high exactly 85 of every 255 cycles, measured over
//     3 periods.

Source files
------------

// File: rtl/acionador_lampada.sv
// Lamp-side receiver: filters the 2-bit command, ramps brightness toward the
// commanded level, drives PWM and forces the lamp off after a long vacancy.
module acionador_lampada #(
    parameter int RAMP_DIV       = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       presenca,
    output logic       lampada,
    output logic [7:0] brilho,
    output logic [1:0] estado,
    output logic [1:0] cmd_aceito,
    output logic       apagou_timeout
);

    localparam int STW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [STW-1:0] ST_MAX = STW'(STABLE_CYCLES);
    localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0]  P_MAX  = PW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        DESLIGADA = 2'b00,
        SUBINDO   = 2'b01,
        ESTAVEL   = 2'b10,
        DESCENDO  = 2'b11
    } estado_t;

    estado_t        st_q;
    estado_t        st_d;
    logic [1:0]     cand;
    logic [STW-1:0] cnt;
    logic [STW-1:0] cnt_inc;
    logic [TOW-1:0] ocioso;
    logic [TOW-1:0] ocioso_inc;
    logic [PW-1:0]  presc;
    logic [7:0]     pwm_cnt;
    logic [7:0]     alvo_cmd;
    logic [7:0]     alvo;
    logic           rampa;

    function automatic logic [7:0] nivel(input logic [1:0] c);
        logic [7:0] n;
        unique case (c)
            2'b00:   n = 8'd0;
            2'b01:   n = 8'd85;
            2'b10:   n = 8'd170;
            default: n = 8'd255;
        endcase
        return n;
    endfunction

    assign cnt_inc    = cnt + 1'b1;
    assign ocioso_inc = ocioso + 1'b1;
    assign alvo_cmd   = nivel(cmd_aceito);
    assign alvo       = apagou_timeout ? 8'd0 : alvo_cmd;
    assign rampa      = (st_q == SUBINDO) || (st_q == DESCENDO);
    assign estado     = st_q;

    // Glitch filter: a command is accepted only after enough equal samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand       <= 2'b00;
            cnt        <= '0;
            cmd_aceito <= 2'b00;
        end else if (cmd != cand) begin
            cand <= cmd;
            cnt  <= STW'(1);
            if (STABLE_CYCLES == 1)
                cmd_aceito <= cmd;
        end else if (cnt < ST_MAX) begin
            cnt <= cnt_inc;
            if (cnt_inc == ST_MAX)
                cmd_aceito <= cand;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ocioso         <= '0;
            apagou_timeout <= 1'b0;
        end else if (presenca) begin
            ocioso         <= '0;
            apagou_timeout <= 1'b0;
        end else if (alvo_cmd != 8'd0 && ocioso < TO_MAX) begin
            ocioso <= ocioso_inc;
            if (ocioso_inc == TO_MAX)
                apagou_timeout <= 1'b1;
        end
    end

    always_comb begin
        st_d = st_q;
        if (brilho < alvo)
            st_d = SUBINDO;
        else if (brilho > alvo)
            st_d = DESCENDO;
        else if (alvo == 8'd0)
            st_d = DESLIGADA;
        else
            st_d = ESTAVEL;
    end

    always_ff @(posedge clock) begin
        if (reset)
            st_q <= DESLIGADA;
        else
            st_q <= st_d;
    end

    // Direction is taken from the live comparison, so a retarget never overshoots.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc  <= '0;
            brilho <= 8'd0;
        end else if (!rampa) begin
            presc <= '0;
        end else if (presc == P_MAX) begin
            presc <= '0;
            if (brilho < alvo)
                brilho <= brilho + 8'd1;
            else if (brilho > alvo)
                brilho <= brilho - 8'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt <= 8'd0;
            lampada <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
            lampada <= (pwm_cnt < brilho);
        end
    end

endmodule

// File: tb/tb_acionador_lampada.sv
// Bench for acionador_lampada: vector table, directed ramp/timeout/PWM
// sequences and random stimulus against a behavioural model.
module tb_acionador_lampada;

    localparam int RD = 4;
    localparam int SC = 3;
    localparam int TO = 1000;

    logic       clock;
    logic       reset;
    logic [1:0] cmd;
    logic       presenca;
    logic       lampada;
    logic [7:0] brilho;
    logic [1:0] estado;
    logic [1:0] cmd_aceito;
    logic       apagou_timeout;

    int tests;
    int fails;

    acionador_lampada #(
        .RAMP_DIV(RD),
        .STABLE_CYCLES(SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd(cmd),
        .presenca(presenca),
        .lampada(lampada),
        .brilho(brilho),
        .estado(estado),
        .cmd_aceito(cmd_aceito),
        .apagou_timeout(apagou_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model state
    logic [1:0] m_q[$];
    int m_acc, m_idle, m_flag, m_bri, m_tick, m_est, m_cyc, m_lamp;

    task automatic model_step(input logic r, input logic [1:0] c, input logic p);
        int a_cmd, a, n_acc, n_idle, n_flag, n_bri, n_tick, n_est;
        bit same;
        if (r) begin
            m_q.delete();
            m_acc = 0; m_idle = 0; m_flag = 0; m_bri = 0;
            m_tick = 0; m_est = 0; m_cyc = 0; m_lamp = 0;
            return;
        end
        a_cmd = m_acc * 85;
        a = m_flag ? 0 : a_cmd;
        m_q.push_back(c);
        if (m_q.size() > SC) void'(m_q.pop_front());
        same = (m_q.size() == SC);
        foreach (m_q[i]) if (m_q[i] != c) same = 0;
        n_acc = same ? int'(c) : m_acc;
        if (p) n_idle = 0;
        else if (a_cmd != 0) n_idle = (m_idle + 1 > TO) ? TO : m_idle + 1;
        else n_idle = m_idle;
        n_flag = (!p && n_idle >= TO) ? 1 : 0;
        if (m_bri < a) n_est = 1;
        else if (m_bri > a) n_est = 3;
        else n_est = (a == 0) ? 0 : 2;
        n_bri = m_bri;
        n_tick = 0;
        if (m_est == 1 || m_est == 3) begin
            n_tick = m_tick + 1;
            if (n_tick == RD) begin
                n_tick = 0;
                n_bri = m_bri + ((a > m_bri) ? 1 : 0) - ((a < m_bri) ? 1 : 0);
            end
        end
        m_lamp = ((m_cyc % 255) < m_bri) ? 1 : 0;
        m_cyc++;
        m_acc = n_acc; m_idle = n_idle; m_flag = n_flag;
        m_bri = n_bri; m_tick = n_tick; m_est = n_est;
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic [1:0] c, input logic p);
        logic [13:0] got, exp;
        reset = r; cmd = c; presenca = p;
        @(posedge clock);
        model_step(r, c, p);
        #1;
        got = {lampada, brilho, estado, cmd_aceito, apagou_timeout};
        exp = {m_lamp[0], m_bri[7:0], m_est[1:0], m_acc[1:0], m_flag[0]};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model: got %h expected %h at %0t", got, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] c;
        logic       p;
        logic [1:0] acc;
        logic [1:0] est;
        logic [7:0] bri;
        logic       lamp;
        logic       flag;
    } vec_t;

    vec_t tbl[23];

    initial begin
        int lo, ones, seg, pv, cv;
        bit seen_desc;
        tests = 0; fails = 0;
        reset = 1'b1; cmd = 2'b11; presenca = 1'b1;
        model_step(1'b1, 2'b11, 1'b1);

        tbl[0] = '{1'b1, 2'b11, 1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0};
        tbl[1] = tbl[0];
        for (int i = 2; i < 12; i++)
            tbl[i] = '{1'b0, 2'b00, 1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b01, 1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0};
        tbl[13] = tbl[12];
        tbl[14] = '{1'b0, 2'b00, 1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'b10, 1'b1, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0};
        tbl[16] = tbl[15];
        tbl[17] = '{1'b0, 2'b10, 1'b1, 2'd2, 2'd0, 8'd0, 1'b0, 1'b0};
        for (int i = 18; i < 22; i++)
            tbl[i] = '{1'b0, 2'b10, 1'b1, 2'd2, 2'd1, 8'd0, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 2'b10, 1'b1, 2'd2, 2'd1, 8'd1, 1'b0, 1'b0};

        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].rst, tbl[i].c, tbl[i].p);
            check_eq($sformatf("vec%0d", i),
                     int'({lampada, brilho, estado, cmd_aceito, apagou_timeout}),
                     int'({tbl[i].lamp, tbl[i].bri, tbl[i].est, tbl[i].acc, tbl[i].flag}));
        end

        // Full ramp 0 -> 255
        tick(1'b1, 2'b00, 1'b1);
        tick(1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'b11, 1'b1);
        check_eq("accept11", int'(cmd_aceito), 3);
        tick(1'b0, 2'b11, 1'b1);
        check_eq("enter_subindo", int'(estado), 1);
        for (int i = 0; i < 1019; i++) tick(1'b0, 2'b11, 1'b1);
        check_eq("ramp_254", int'(brilho), 254);
        tick(1'b0, 2'b11, 1'b1);
        check_eq("ramp_255", int'(brilho), 255);
        tick(1'b0, 2'b11, 1'b1);
        check_eq("estavel_255", int'(estado), 2);
        tick(1'b0, 2'b11, 1'b1);
        ones = 0;
        for (int i = 0; i < 255; i++) begin
            tick(1'b0, 2'b11, 1'b1);
            ones += int'(lampada);
        end
        check_eq("pwm_full_on", ones, 255);

        // Short glitch must not reach cmd_aceito
        tick(1'b0, 2'b00, 1'b1);
        tick(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 2'b11, 1'b1);
            check_eq("glitch_acc", int'(cmd_aceito), 3);
            check_eq("glitch_bri", int'(brilho), 255);
        end

        // Interrupted ramp-up retargets down to 85
        tick(1'b1, 2'b00, 1'b1);
        tick(1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 600 && brilho != 8'd100; i++) tick(1'b0, 2'b11, 1'b1);
        check_eq("reach_100", int'(brilho), 100);
        lo = 255; seen_desc = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 2'b01, 1'b1);
            if (int'(brilho) < lo) lo = int'(brilho);
            if (estado == 2'b11) seen_desc = 1;
        end
        check_eq("no_under_85", (lo >= 85) ? 1 : 0, 1);
        check_eq("saw_descendo", int'(seen_desc), 1);
        check_eq("settle_85", int'(brilho), 85);
        check_eq("settle_est", int'(estado), 2);

        // Timeout from 170 and recovery
        for (int i = 0; i < 400; i++) tick(1'b0, 2'b10, 1'b1);
        check_eq("at_170", int'(brilho), 170);
        for (int i = 0; i < 999; i++) tick(1'b0, 2'b10, 1'b0);
        check_eq("no_flag_999", int'(apagou_timeout), 0);
        tick(1'b0, 2'b10, 1'b0);
        check_eq("flag_1000", int'(apagou_timeout), 1);
        for (int i = 0; i < 700; i++) tick(1'b0, 2'b10, 1'b0);
        check_eq("to_off_bri", int'(brilho), 0);
        check_eq("to_off_est", int'(estado), 0);
        check_eq("to_hold", int'(apagou_timeout), 1);
        tick(1'b0, 2'b10, 1'b1);
        check_eq("flag_clear", int'(apagou_timeout), 0);
        for (int i = 0; i < 700; i++) tick(1'b0, 2'b10, 1'b1);
        check_eq("back_170", int'(brilho), 170);
        check_eq("back_est", int'(estado), 2);

        // PWM duty at 85
        for (int i = 0; i < 400; i++) tick(1'b0, 2'b01, 1'b1);
        check_eq("steady_85", int'(brilho), 85);
        ones = 0;
        for (int i = 0; i < 765; i++) begin
            tick(1'b0, 2'b01, 1'b1);
            ones += int'(lampada);
        end
        check_eq("pwm_duty_85", ones, 255);

        // Random stimulus against the model
        tick(1'b1, 2'b00, 1'b1);
        for (int n = 0; n < 7000; n += seg) begin
            cv = int'($urandom_range(0, 3));
            pv = ($urandom_range(0, 7) != 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) seg = int'($urandom_range(1, 2));
            else if (pv == 0 && $urandom_range(0, 3) == 0) seg = 1100;
            else seg = int'($urandom_range(1, 300));
            if ($urandom_range(0, 60) == 0) begin
                tick(1'b1, 2'(cv), 1'(pv));
                seg = 1;
            end else begin
                for (int i = 0; i < seg; i++) tick(1'b0, 2'(cv), 1'(pv));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
